// File: rtl/key_debouncer_pkg.sv
// Shared types and helpers for the key debouncer: channel state encoding,
// output decodes and polarity helpers.
package key_debouncer_pkg;

  // Per-channel qualification state; encodings are fixed and all four are used.
  typedef enum logic [1:0] {
    ST_IDLE_LOW  = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_IDLE_HIGH = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } deb_state_e;

  // Debounced level: pressed while stable high or while qualifying a release.
  function automatic logic state_level(input deb_state_e s);
    return (s == ST_IDLE_HIGH) || (s == ST_WAIT_LOW);
  endfunction

  // Busy: a candidate change is being qualified.
  function automatic logic state_busy(input deb_state_e s);
    return (s == ST_WAIT_HIGH) || (s == ST_WAIT_LOW);
  endfunction

  // Raw pin level of a released key for the given polarity.
  function automatic logic idle_raw_level(input logic active_low);
    return active_low;
  endfunction

endpackage : key_debouncer_pkg

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchroniser, 4-state qualification FSM and
// hold counter for a single raw key bit.
module debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          KEY_INVERT      = 1'b1,
  parameter bit          RAW_IDLE        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             key_on;
  deb_state_e       state_q;
  deb_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             busy_q;
  logic             busy_d;

  // Two-flop synchroniser; resets to the released raw level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  // Normalise polarity: key_on is 1 while the key is pressed.
  assign key_on = KEY_INVERT ? ~sync2_q : sync2_q;

  // State, counter and registered output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: any reversal during qualification drops back to the idle state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE_LOW: begin
        if (key_on) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!key_on) begin
          state_d = ST_IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE_HIGH: begin
        if (!key_on) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (key_on) begin
          state_d = ST_IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so the flops change on the same edge as the state.
  always_comb begin
    level_d = state_level(state_d);
    busy_d  = state_busy(state_d);
  end

  assign level_o = level_q;
  assign busy_o  = busy_q;

endmodule : debounce_channel

// File: rtl/key_debouncer.sv
// Pushbutton front end: one independent debounce channel per raw key,
// presenting a clean active-high level and a qualifying flag per key.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_busy
);

  localparam bit RAW_IDLE = idle_raw_level(ACTIVE_LOW);

  // Fan the keys out to identical channels; polarity is resolved here once.
  for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .KEY_INVERT      (ACTIVE_LOW),
      .RAW_IDLE        (RAW_IDLE)
    ) u_ch (
      .clk     (Clock),
      .rst     (Reset),
      .key_i   (i_key[g]),
      .level_o (o_level[g]),
      .busy_o  (o_busy[g])
    );
  end

endmodule : key_debouncer
